// File: rtl/dmem_lsu_master.sv
// Split-phase dmem initiator: one load/store at a time, with strobe/lane generation,
// load extraction and misalignment/bus-error/timeout reporting.
module dmem_lsu_master #(
    parameter int unsigned p_ADDR_BITS = 32,
    parameter int unsigned p_DATA_BITS = 32,
    parameter int unsigned p_STRB_BITS = p_DATA_BITS / 8,
    parameter int unsigned p_TIMEOUT   = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_cmd_i,
    input  logic [1:0]             req_size_i,
    input  logic                   req_unsigned_i,
    input  logic [p_ADDR_BITS-1:0] req_addr_i,
    input  logic [p_DATA_BITS-1:0] req_wdata_i,
    output logic                   resp_valid_o,
    output logic [p_DATA_BITS-1:0] resp_rdata_o,
    output logic                   resp_err_o,
    output logic                   resp_misaligned_o,
    output logic                   resp_timeout_o,
    output logic [p_ADDR_BITS-1:0] mem_addr_o,
    output logic                   mem_cmd_o,
    output logic [1:0]             mem_size_o,
    output logic                   mem_valid_o,
    input  logic                   mem_ready_i,
    output logic                   mem_r_ready_o,
    input  logic                   mem_r_valid_i,
    input  logic [p_DATA_BITS-1:0] mem_r_data_i,
    input  logic                   mem_r_resp_i,
    output logic                   mem_w_valid_o,
    input  logic                   mem_w_ready_i,
    output logic [p_STRB_BITS-1:0] mem_w_strb_o,
    output logic [p_DATA_BITS-1:0] mem_w_data_o,
    input  logic                   mem_w_resp_i
);
    localparam int unsigned TMO_W = $clog2(p_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RDATA, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic                   cmd_q, cmd_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic [p_ADDR_BITS-1:0] addr_q, addr_d;
    logic [p_STRB_BITS-1:0] strb_q, strb_d;
    logic [p_DATA_BITS-1:0] wdata_q, wdata_d;
    logic [p_DATA_BITS-1:0] rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   mis_q, mis_d;
    logic                   tout_q, tout_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;

    logic                   bad_req;
    logic                   tmo_max;
    logic [p_STRB_BITS-1:0] strb_new;
    logic [p_DATA_BITS-1:0] wdata_new;
    logic [p_DATA_BITS-1:0] sh;
    logic [p_DATA_BITS-1:0] load_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            tout_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            tout_q  <= tout_d;
            tmo_q   <= tmo_d;
        end
    end

    // Request-side decode: alignment check, byte lanes and replicated store data.
    always_comb begin
        bad_req   = 1'b0;
        strb_new  = '0;
        wdata_new = req_wdata_i;
        unique case (req_size_i)
            2'd0: begin
                strb_new  = p_STRB_BITS'(1) << req_addr_i[1:0];
                wdata_new = {(p_DATA_BITS/8){req_wdata_i[7:0]}};
            end
            2'd1: begin
                bad_req   = req_addr_i[0];
                strb_new  = p_STRB_BITS'(3) << req_addr_i[1:0];
                wdata_new = {(p_DATA_BITS/16){req_wdata_i[15:0]}};
            end
            2'd2: begin
                bad_req  = (req_addr_i[1:0] != 2'b00);
                strb_new = '1;
            end
            default: bad_req = 1'b1;
        endcase
    end

    always_comb begin
        sh       = mem_r_data_i >> {addr_q[1:0], 3'b000};
        load_ext = sh;
        unique case (size_q)
            2'd0:    load_ext = {{(p_DATA_BITS-8){~uns_q & sh[7]}}, sh[7:0]};
            2'd1:    load_ext = {{(p_DATA_BITS-16){~uns_q & sh[15]}}, sh[15:0]};
            default: load_ext = sh;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mis_d   = mis_q;
        tout_d  = tout_q;
        tmo_d   = tmo_q;
        tmo_max = (tmo_q == TMO_W'(p_TIMEOUT - 1));
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    cmd_d   = req_cmd_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    strb_d  = strb_new;
                    wdata_d = wdata_new;
                    rdata_d = '0;
                    err_d   = bad_req;
                    mis_d   = bad_req;
                    tout_d  = 1'b0;
                    tmo_d   = '0;
                    state_d = bad_req ? S_DONE : S_CMD;
                end
            end
            S_CMD: begin
                // A completing handshake wins over a timeout landing in the same cycle.
                if (cmd_q && mem_ready_i && mem_w_ready_i) begin
                    err_d   = mem_w_resp_i;
                    state_d = S_DONE;
                end else if (!cmd_q && mem_ready_i) begin
                    tmo_d   = '0;
                    state_d = S_RDATA;
                end else if (tmo_max) begin
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RDATA: begin
                if (mem_r_valid_i) begin
                    err_d   = mem_r_resp_i;
                    rdata_d = mem_r_resp_i ? '0 : load_ext;
                    state_d = S_DONE;
                end else if (tmo_max) begin
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o       = (state_q == S_IDLE);
    assign resp_valid_o      = (state_q == S_DONE);
    assign resp_rdata_o      = (state_q == S_DONE) ? rdata_q : '0;
    assign resp_err_o        = (state_q == S_DONE) & err_q;
    assign resp_misaligned_o = (state_q == S_DONE) & mis_q;
    assign resp_timeout_o    = (state_q == S_DONE) & tout_q;
    assign mem_addr_o        = addr_q;
    assign mem_cmd_o         = cmd_q;
    assign mem_size_o        = size_q;
    assign mem_valid_o       = (state_q == S_CMD);
    assign mem_w_valid_o     = (state_q == S_CMD) & cmd_q;
    assign mem_r_ready_o     = (state_q == S_RDATA);
    assign mem_w_strb_o      = strb_q;
    assign mem_w_data_o      = wdata_q;

endmodule
